// File: rtl/mod10_pkg.sv
// mod10_pkg: shared states, BCD constants and nibble saturation for the mod-10 counters
package mod10_pkg;
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction
endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: one combinational BCD decade decrementer with borrow chain
module bcd_digit_dec
    import mod10_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    input  logic             i_borrow,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_borrow
);
    logic w_zero;
    assign w_zero   = (i_digit == '0);
    assign o_borrow = i_borrow && w_zero;
    assign o_digit  = !i_borrow ? i_digit : w_zero ? BCD_MAX : i_digit - 4'd1;
endmodule

// File: rtl/sync_mod10_down_counter.sv
// sync_mod10_down_counter: cascaded BCD down counter with load/start/enable and expiry flag
// Optional: SYNC_MOD10_AUTO_RELOAD_EN reloads from the last loaded value at zero and pulses borrow.
module sync_mod10_down_counter
    import mod10_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  start,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   q,
    output logic                  running,
    output logic                  done,
    output logic                  borrow
);
    state_t                r_state;
    logic [4*DIGITS-1:0]   r_q;
    logic                  r_running;
    logic                  r_done;
    logic [4*DIGITS-1:0]   w_din_sat;
    logic [4*DIGITS-1:0]   w_next;
    logic [DIGITS:0]       w_bc;
`ifdef SYNC_MOD10_AUTO_RELOAD_EN
    logic [4*DIGITS-1:0]   r_reload;
    logic                  r_borrow;
`endif

    // The borrow chain starts at en; a borrow out of the top decade means en=1 with q=0.
    assign w_bc[0] = en;
    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        assign w_din_sat[d*BCD_W +: BCD_W] = bcd_sat(din[d*BCD_W +: BCD_W]);
        bcd_digit_dec u_dec (
            .i_digit  (r_q[d*BCD_W +: BCD_W]),
            .i_borrow (w_bc[d]),
            .o_digit  (w_next[d*BCD_W +: BCD_W]),
            .o_borrow (w_bc[d+1])
        );
    end

    // Control priority: clear, load, start, then count/expire in RUN.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state   <= IDLE;
            r_q       <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
`ifdef SYNC_MOD10_AUTO_RELOAD_EN
            r_reload  <= '0;
            r_borrow  <= 1'b0;
`endif
        end else begin
`ifdef SYNC_MOD10_AUTO_RELOAD_EN
            r_borrow <= 1'b0;
`endif
            if (load) begin
                r_q       <= w_din_sat;
                r_state   <= IDLE;
                r_running <= 1'b0;
                r_done    <= 1'b0;
`ifdef SYNC_MOD10_AUTO_RELOAD_EN
                r_reload  <= w_din_sat;
`endif
            end else if (start && r_state != RUN) begin
                r_state   <= RUN;
                r_running <= 1'b1;
                r_done    <= 1'b0;
            end else if (r_state == RUN && w_bc[DIGITS]) begin
`ifdef SYNC_MOD10_AUTO_RELOAD_EN
                r_q       <= r_reload;
                r_borrow  <= 1'b1;
`else
                r_state   <= EXPIRED;
                r_running <= 1'b0;
                r_done    <= 1'b1;
`endif
            end else if (r_state == RUN && en) begin
                r_q <= w_next;
            end
        end
    end

    assign q       = r_q;
    assign running = r_running;
    assign done    = r_done;
`ifdef SYNC_MOD10_AUTO_RELOAD_EN
    assign borrow  = r_borrow;
`else
    assign borrow  = 1'b0;
`endif
endmodule

// File: tb/tb_sync_mod10_down_counter.sv
// tb_sync_mod10_down_counter: decimal-value model plus directed literal checks for the BCD down counter
module tb_sync_mod10_down_counter;
    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       load  = 1'b0;
    logic [7:0] din   = 8'h00;
    logic       start = 1'b0;
    logic       en    = 1'b0;
    logic [7:0] q;
    logic       running;
    logic       done;
    logic       borrow;
    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;
    int m_val = 0;
    int m_rl  = 0;
    int m_st  = 0;
    bit m_b   = 1'b0;

    sync_mod10_down_counter #(.DIGITS(2)) dut (
        .clock(clock), .clear(clear), .load(load), .din(din), .start(start),
        .en(en), .q(q), .running(running), .done(done), .borrow(borrow)
    );

    always #5 clock = ~clock;

    function automatic int satval(input logic [7:0] d);
        int lo, hi;
        lo = (d[3:0] > 9) ? 9 : int'(d[3:0]);
        hi = (d[7:4] > 9) ? 9 : int'(d[7:4]);
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] tobcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'((v / 10) % 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: decimal count value with state codes 0=idle 1=run 2=expired.
    always @(posedge clock) begin : mdl
        int v, st, rl;
        bit b;
        v = m_val; st = m_st; rl = m_rl; b = 1'b0;
        if (clear) begin
            v = 0; st = 0; rl = 0;
        end else if (load) begin
            v = satval(din); rl = v; st = 0;
        end else if (start && st != 1) begin
            st = 1;
        end else if (st == 1 && en) begin
            if (v > 0) v = v - 1;
`ifdef SYNC_MOD10_AUTO_RELOAD_EN
            else begin v = rl; b = 1'b1; end
`else
            else st = 2;
`endif
        end
        m_val <= v; m_st <= st; m_rl <= rl; m_b <= b;
    end

    always @(negedge clock) begin
        if (armed) begin
            chk("q_model", 32'(q), 32'(tobcd(m_val)));
            chk("running_model", 32'(running), 32'(m_st == 1));
            chk("done_model", 32'(done), 32'(m_st == 2));
            chk("borrow_model", 32'(borrow), 32'(m_b));
        end
    end

    task automatic cyc(input logic l, input logic [7:0] d, input logic s, input logic e);
        clear = 1'b0; load = l; din = d; start = s; en = e;
        @(negedge clock);
    endtask

    logic [7:0] cd [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                            8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

    initial begin
        @(negedge clock);
        @(negedge clock);
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        armed = 1'b1;
        // Count 12 down to zero then expire (or reload).
        cyc(1, 8'h12, 0, 0);
        chk("load12_q", 32'(q), 32'h12);
        cyc(0, 8'h00, 1, 0);
        chk("start12_running", 32'(running), 32'd1);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 8'h00, 0, 1);
            chk("count12_q", 32'(q), 32'(cd[i]));
        end
        cyc(0, 8'h00, 0, 1);
`ifdef SYNC_MOD10_AUTO_RELOAD_EN
        chk("wrap12_q", 32'(q), 32'h12);
        chk("wrap12_borrow", 32'(borrow), 32'd1);
`else
        chk("exp12_done", 32'(done), 32'd1);
        chk("exp12_running", 32'(running), 32'd0);
        chk("exp12_q", 32'(q), 32'h00);
        cyc(0, 8'h00, 0, 1);
        chk("exp12_hold_q", 32'(q), 32'h00);
        chk("exp12_hold_done", 32'(done), 32'd1);
`endif
        // Saturation of nibbles above 9.
        cyc(1, 8'hAF, 0, 0);
        chk("sat_q", 32'(q), 32'h99);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1);
        chk("sat_dec_q", 32'(q), 32'h98);
        cyc(1, 8'h5C, 0, 0);
        chk("sat_lo_q", 32'(q), 32'h59);
        // Enable toggling with a borrow across decades.
        cyc(1, 8'h40, 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1); chk("tog1_q", 32'(q), 32'h39);
        cyc(0, 8'h00, 0, 0); chk("tog2_q", 32'(q), 32'h39);
        cyc(0, 8'h00, 0, 1); chk("tog3_q", 32'(q), 32'h38);
        cyc(0, 8'h00, 0, 0); chk("tog4_q", 32'(q), 32'h38);
        // Load beats start mid-run.
        cyc(1, 8'h05, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("mid_running", 32'(running), 32'd1);
        cyc(1, 8'h30, 1, 1);
        chk("mid_q", 32'(q), 32'h30);
        chk("mid_running_off", 32'(running), 32'd0);
        cyc(0, 8'h00, 0, 1);
        chk("idle_hold_q", 32'(q), 32'h30);
        // Start from zero and restart after expiry.
        cyc(1, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("zero_start_running", 32'(running), 32'd1);
        cyc(0, 8'h00, 0, 1);
`ifdef SYNC_MOD10_AUTO_RELOAD_EN
        chk("zero_reload_borrow", 32'(borrow), 32'd1);
`else
        chk("zero_exp_done", 32'(done), 32'd1);
        cyc(0, 8'h00, 1, 0);
        chk("restart_running", 32'(running), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
`endif
`ifdef SYNC_MOD10_AUTO_RELOAD_EN
        cyc(1, 8'h02, 0, 0);
        cyc(0, 8'h00, 1, 0); chk("ar0_q", 32'(q), 32'h02);
        cyc(0, 8'h00, 0, 1); chk("ar1_q", 32'(q), 32'h01);
        cyc(0, 8'h00, 0, 1); chk("ar2_q", 32'(q), 32'h00);
        chk("ar2_borrow", 32'(borrow), 32'd0);
        cyc(0, 8'h00, 0, 1); chk("ar3_q", 32'(q), 32'h02);
        chk("ar3_borrow", 32'(borrow), 32'd1);
        cyc(0, 8'h00, 0, 1); chk("ar4_q", 32'(q), 32'h01);
        chk("ar4_borrow", 32'(borrow), 32'd0);
        chk("ar4_done", 32'(done), 32'd0);
`endif
        // Clear mid-run.
        cyc(1, 8'h25, 0, 0);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 0, 1);
        chk("pre_clr_q", 32'(q), 32'h24);
        clear = 1'b1; en = 1'b1;
        @(negedge clock);
        chk("clr_q", 32'(q), 32'h00);
        chk("clr_running", 32'(running), 32'd0);
        chk("clr_borrow", 32'(borrow), 32'd0);
        cyc(0, 8'h00, 0, 0);
        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_mod10_down_counter.md
# sync_mod10_down_counter

Synchronous, cascaded-decade (BCD) down counter with parallel load, start/enable control and a terminal-count flag. It complements the team's ripple mod-10 up counters: those count events upward, while this block counts a loaded BCD value down to zero. All flops share one clock, so `q` never shows ripple glitches. It sits beside the seven-segment/BCD display path as a countdown timer.

## Interface
Parameters:
- `DIGITS`, default 2: number of BCD decades; `q`/`din` width is 4*DIGITS.

Ports:
- `clock`  in  1: single clock; all state changes on its rising edge.
- `clear`  in  1: reset, synchronous, active-high.
- `load`  in  1: capture `din` into count and reload registers.
- `din`  in  4*DIGITS: BCD load value; nibble [3:0] is the least-significant decade.
- `start`  in  1: begin counting from the current count.
- `en`  in  1: count enable; decrement only in cycles with `en`=1.
- `q`  out  4*DIGITS: current BCD count, registered.
- `running`  out  1: 1 while in RUN.
- `done`  out  1: level; 1 while in EXPIRED.
- `borrow`  out  1: one-cycle pulse on wrap/reload from zero (AUTO_RELOAD_EN only).

## Operation
- States: IDLE, RUN, EXPIRED. Reset: state IDLE, `q`=0, reload register=0, `running`=0, `done`=0, `borrow`=0.
- Priority each cycle: `clear` > `load` > `start` > count.
- `load` (any state): each `din` nibble >9 saturates to 9. Count and reload register take the saturated value; state goes to IDLE; `done` clears. `start` in the same cycle is ignored.
- `start` in IDLE or EXPIRED: state goes to RUN. `start` in RUN: no effect.
- RUN with `en`=1 and `q`≠0: decrement BCD.
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows into the next digit.
  - Digits above the borrow chain hold.
- RUN with `en`=1 and `q`=0 (without the macro): state goes to EXPIRED, `q` holds 0.
- RUN with `en`=0: hold.
- EXPIRED: `q` holds. Leave only via `load` (to IDLE) or `start` (to RUN).
- `start` with `q`=0 enters RUN. The next enabled cycle expires it.
- `clear` mid-run: returns to the reset values above, no `borrow` pulse.

## Timing
- All outputs are registered and update one clock after the qualifying input edge; there are no combinational paths from inputs to outputs.
- From `q`=N in RUN with `en` held at 1: `q`=0 after N cycles (N = decimal value of the BCD count), and `done`=1 at cycle N+1.
- `running` and `done` change in the same edge as the state.

## Configuration
- `SYNC_MOD10_AUTO_RELOAD_EN` defined:
  - RUN with `en`=1 and `q`=0 loads the reload register into `q`.
  - `borrow` pulses 1 for exactly that cycle; the state stays RUN.
  - EXPIRED is unreachable except by reset.
- Macro absent:
  - `borrow` is tied to 0.
  - The reload register is not instantiated; `load` still writes `q`.

## Structure
- Shared package `mod10_pkg`:
  - state enum (IDLE/RUN/EXPIRED)
  - `BCD_MAX`=4'd9
  - `BCD_W`=4
  - saturation function for one nibble
- Sub-module `bcd_digit_dec`: one combinational decade.
  - Inputs: digit, borrow-in.
  - Outputs: next digit, borrow-out (digit==0 && borrow-in).
  - Instantiate DIGITS times in a generate chain; digit 0 borrow-in = `en`.

## Test plan
- Reset: assert `clear` 2 cycles -> `q`=8'h00, `running`=0, `done`=0, `borrow`=0.
- Load 8'h12, `start`, `en`=1 continuous -> `q` 12,11,10,09,…,00 over 12 cycles; cycle 13: `done`=1, `running`=0, `q`=00.
- Load 8'hAF -> `q`=8'h99. Then `start` + 1 enabled cycle -> `q`=8'h98.
- Load 8'h40, `start`, `en` toggling 1,0,1,0 -> `q` 39,39,38,38.
- Load mid-run: in RUN at `q`=8'h05, `load`+`start` with `din`=8'h30 -> `q`=8'h30, state IDLE, `start` ignored.
- With SYNC_MOD10_AUTO_RELOAD_EN: load 8'h02, `start`, `en`=1 -> `q` 02,01,00,02,01; `borrow`=1 only in the cycle `q` returns to 02; `done` stays 0.
